dw3_32_gen: RTL and testbench

Delta-weight generator for the output-layer weight register of the backpropagation network. Computes the update `dw3_32 = lr × delta3_2 × a2_3` in signed Q5.10 with a sequential shift-add multiplier. It drives the weight register's `dw3_32`, `select_initial` and `select_update` inputs, so it acts as the producer/controller side of that register's update interface. Sequencing is a start/done handshake from the training controller.

---
 rtl/dw3_32_gen.sv | 139 +++++++++++++
 tb/tb_dw3_32_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dw3_32_gen.sv
// dw3_32_gen: delta weight dw3_32 = 2^-LR_SHIFT * delta * act (signed Q5.10), using a sequential shift-add multiplier.
// Optional macro DW_SATURATE_EN clamps the scaled result to 16 bits instead of wrapping it.
module dw3_32_gen #(
   parameter int LR_SHIFT = 3,
   parameter int FRAC     = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_req,
   input  logic        start,
   input  logic [15:0] delta,
   input  logic [15:0] act,
   output logic        busy,
   output logic        done,
   output logic [15:0] dw3_32,
   output logic        select_initial,
   output logic        select_update
);
   localparam int SHIFT = FRAC + LR_SHIFT;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      MUL    = 3'd2,
      SCALE  = 3'd3,
      UPDATE = 3'd4
   } state_t;

   state_t             state_r;
   logic        [3:0]  cnt_r;
   logic        [31:0] acc_r;
   logic        [31:0] mcand_r;
   logic        [15:0] mplier_r;
   logic               neg_r;
   logic signed [31:0] prod_s;
   logic        [15:0] result_s;
`ifdef DW_SATURATE_EN
   logic signed [31:0] scaled_s;
`endif

   // 0x8000 maps to the unsigned magnitude 0x8000, so -32.0 stays exact
   function automatic logic [15:0] magnitude(input logic [15:0] v);
      if (v[15]) begin
         magnitude = 16'd0 - v;
      end else begin
         magnitude = v;
      end
   endfunction

   // Sign-correct the product, floor-shift it and reduce it to 16 bits
   always_comb begin
      prod_s = neg_r ? -$signed(acc_r) : $signed(acc_r);
`ifdef DW_SATURATE_EN
      scaled_s = prod_s >>> SHIFT;
      if (scaled_s > 32'sd32767) begin
         result_s = 16'h7FFF;
      end else if (scaled_s < -32'sd32768) begin
         result_s = 16'h8000;
      end else begin
         result_s = scaled_s[15:0];
      end
`else
      result_s = 16'(prod_s >>> SHIFT);
`endif
   end

   // Control FSM, multiplier datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r        <= IDLE;
         cnt_r          <= 4'd0;
         acc_r          <= 32'd0;
         mcand_r        <= 32'd0;
         mplier_r       <= 16'd0;
         neg_r          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         dw3_32         <= 16'd0;
         select_initial <= 1'b0;
         select_update  <= 1'b0;
      end else begin
         done           <= 1'b0;
         select_initial <= 1'b0;
         select_update  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (init_req) begin
                  state_r        <= INIT;
                  busy           <= 1'b1;
                  select_initial <= 1'b1;
               end else if (start) begin
                  state_r  <= MUL;
                  busy     <= 1'b1;
                  cnt_r    <= 4'd0;
                  acc_r    <= 32'd0;
                  mcand_r  <= {16'd0, magnitude(delta)};
                  mplier_r <= magnitude(act);
                  neg_r    <= delta[15] ^ act[15];
               end else begin
                  busy <= 1'b0;
               end
            end
            INIT: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            MUL: begin
               if (mplier_r[0]) begin
                  acc_r <= acc_r + mcand_r;
               end else begin
                  acc_r <= acc_r;
               end
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + 4'd1;
               if (cnt_r == 4'd15) begin
                  state_r <= SCALE;
               end else begin
                  state_r <= MUL;
               end
            end
            SCALE: begin
               dw3_32        <= result_s;
               done          <= 1'b1;
               select_update <= 1'b1;
               state_r       <= UPDATE;
            end
            UPDATE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dw3_32_gen.sv
// Self-checking bench for dw3_32_gen: two instances (LR_SHIFT=3 and LR_SHIFT=0) share stimulus.
// Directed table, hand-written corner sequences, and random vectors against an arithmetic model.
module tb_dw3_32_gen;
`ifdef DW_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        init_req = 1'b0;
   logic        start = 1'b0;
   logic [15:0] delta = 16'h0000;
   logic [15:0] act = 16'h0000;
   logic        busy3, done3, si3, su3;
   logic [15:0] dw3;
   logic        busy0, done0, si0, su0;
   logic [15:0] dw0;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dw3_32_gen #(.LR_SHIFT(3), .FRAC(10)) u_lr3 (
      .clk(clk), .reset(reset), .init_req(init_req), .start(start),
      .delta(delta), .act(act), .busy(busy3), .done(done3), .dw3_32(dw3),
      .select_initial(si3), .select_update(su3)
   );

   dw3_32_gen #(.LR_SHIFT(0), .FRAC(10)) u_lr0 (
      .clk(clk), .reset(reset), .init_req(init_req), .start(start),
      .delta(delta), .act(act), .busy(busy0), .done(done0), .dw3_32(dw0),
      .select_initial(si0), .select_update(su0)
   );

   typedef struct {
      logic [15:0] d;
      logic [15:0] a;
      logic [15:0] w3;
      logic [15:0] s3;
      logic [15:0] w0;
      logic [15:0] s0;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // floor(delta*act / 2^(10+lr)), then wrap or clamp to 16 bits
   function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] a, input int lr);
      longint p, dv, q;
      p  = longint'($signed(d)) * longint'($signed(a));
      dv = longint'(1) << (10 + lr);
      q  = p / dv;
      if ((p % dv != 0) && (p < 0)) q = q - 1;
      if (SAT) begin
         if (q > 32767) q = 32767;
         if (q < -32768) q = -32768;
      end
      return q[15:0];
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy3 || busy0) && n < 40) begin
         tick();
         n++;
      end
      if (busy3 || busy0) check("idle timeout", 1, 0);
   endtask

   task automatic count_pulses(input int cycles, output int nd, output int ni);
      nd = 0;
      ni = 0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         nd += int'(done3) + int'(done0);
         ni += int'(si3) + int'(si0);
      end
   endtask

   task automatic run_compute(input string name, input logic [15:0] d, input logic [15:0] a,
                              input logic [15:0] e3, input logic [15:0] e0);
      logic [17:0] pd3, pu3, pd0, pu0;
      logic [15:0] g3, g0;
      logic        si_seen, busy_end;
      pd3 = '0; pu3 = '0; pd0 = '0; pu0 = '0;
      g3 = 16'hxxxx; g0 = 16'hxxxx;
      si_seen = 1'b0; busy_end = 1'b1;
      wait_idle();
      delta = d;
      act   = a;
      start = 1'b1;
      tick();
      start = 1'b0;
      delta = 16'($urandom);
      act   = 16'($urandom);
      check({name, " busy"}, {busy3, busy0}, 2'b11);
      for (int k = 1; k <= 18; k++) begin
         tick();
         pd3[k-1] = done3; pu3[k-1] = su3;
         pd0[k-1] = done0; pu0[k-1] = su0;
         if (si3 || si0) si_seen = 1'b1;
         if (k == 17) begin
            g3 = dw3;
            g0 = dw0;
         end
         if (k == 18) busy_end = busy3 | busy0;
      end
      check({name, " done/upd timing lr3"}, {pd3, pu3}, {18'h10000, 18'h10000});
      check({name, " done/upd timing lr0"}, {pd0, pu0}, {18'h10000, 18'h10000});
      check({name, " dw lr3"}, g3, e3);
      check({name, " dw lr0"}, g0, e0);
      check({name, " idle+no init"}, {busy_end, si_seen}, 2'b00);
   endtask

   initial begin
      int nd, ni;
      logic [15:0] d, a, prev3, prev0;

      vecs[0] = '{16'h0400, 16'h0200, 16'h0040, 16'h0040, 16'h0200, 16'h0200};
      vecs[1] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      vecs[2] = '{16'h7FFF, 16'h7FFF, 16'hFFF8, 16'h7FFF, 16'hFFC0, 16'h7FFF};
      vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF};
      vecs[4] = '{16'h8000, 16'h0400, 16'hF000, 16'hF000, 16'h8000, 16'h8000};
      vecs[5] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[7] = '{16'hFC00, 16'h0200, 16'hFFC0, 16'hFFC0, 16'hFE00, 16'hFE00};

      // reset state
      tick();
      tick();
      check("reset outputs", {busy3, done3, si3, su3, dw3, busy0, done0, si0, su0, dw0}, 0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_compute($sformatf("vec%0d", i), vecs[i].d, vecs[i].a,
                     SAT ? vecs[i].s3 : vecs[i].w3, SAT ? vecs[i].s0 : vecs[i].w0);
      end

      // init_req wins over start; start is dropped
      wait_idle();
      prev3 = dw3;
      prev0 = dw0;
      init_req = 1'b1;
      start    = 1'b1;
      delta    = 16'h0400;
      act      = 16'h0200;
      tick();
      init_req = 1'b0;
      start    = 1'b0;
      check("init pulse", {si3, si0, su3, su0, busy3, busy0}, 6'b110011);
      tick();
      check("init end", {si3, si0, busy3, busy0}, 4'b0000);
      check("init dw hold", {dw3, dw0}, {prev3, prev0});
      count_pulses(25, nd, ni);
      check("init start dropped", {nd, ni}, {32'd0, 32'd0});

      // start/init_req while busy are ignored
      delta = 16'h0400;
      act   = 16'h0200;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      delta = 16'h7FFF;
      act   = 16'h7FFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      count_pulses(35, nd, ni);
      check("busy ignore pulses", {nd, ni}, {32'd2, 32'd0});
      check("busy ignore dw", {dw3, dw0}, {16'h0040, 16'h0200});

      // reset during MUL
      wait_idle();
      delta = 16'hFC00;
      act   = 16'h0200;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      reset = 1'b0;
      tick();
      check("reset mid-mul", {busy3, done3, si3, su3, dw3, busy0, done0, si0, su0, dw0}, 0);
      tick();
      tick();
      reset = 1'b1;
      count_pulses(25, nd, ni);
      check("reset no done", {nd, ni}, {32'd0, 32'd0});
      run_compute("post-reset nominal", 16'h0400, 16'h0200, 16'h0040, 16'h0200);

      // random vectors against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         d = 16'($urandom);
         a = 16'($urandom);
         run_compute($sformatf("rand%0d d=%h a=%h", i, d, a), d, a, model(d, a, 3), model(d, a, 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
